// File: rtl/sync_ptr_w2r_multi.sv
// Multi-channel write-pointer synchroniser for the read side of async FIFOs.
// Each channel carries a Gray-coded write pointer through a SYNC_STAGES-deep
// flop chain into the rclk domain. It then registers three things from the
// synchronised value: its binary form, the modular advance since the previous
// cycle, and a one-cycle strobe that fires whenever that value changed.
module sync_ptr_w2r_multi #(
    parameter int ADDRSIZE    = 4,
    parameter int NUM_CH      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              rclk,
    input  logic                              rrst_n,
    input  logic [NUM_CH*(ADDRSIZE+1)-1:0]    wptr,
    output logic [NUM_CH*(ADDRSIZE+1)-1:0]    rq_wptr_gray,
    output logic [NUM_CH*(ADDRSIZE+1)-1:0]    rq_wptr_bin,
    output logic [NUM_CH*(ADDRSIZE+1)-1:0]    rq_wptr_delta,
    output logic [NUM_CH-1:0]                 rq_wptr_upd
);

    localparam int PW = ADDRSIZE + 1;

    // Fewer than two stages gives no real metastability protection.
    // More than four only adds latency, so both are refused at elaboration.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_depth
            $error("sync_ptr_w2r_multi: SYNC_STAGES must be in 2..4");
        end
        if (NUM_CH < 1) begin : g_bad_ch
            $error("sync_ptr_w2r_multi: NUM_CH must be at least 1");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Only plain flops sit in the chain, with no logic between stages.
            // This keeps the full settling time available to each stage.
            (* ASYNC_REG = "TRUE" *) logic [PW-1:0] sync_reg [SYNC_STAGES];

            logic [PW-1:0] bin_reg;
            logic [PW-1:0] bin_next;
            logic [PW-1:0] delta_reg;
            logic          upd_reg;

            // Gray pointer synchroniser chain; every stage clears on reset
            always_ff @(posedge rclk) begin
                if (!rrst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_reg[k] <= '0;
                    end
                end else begin
                    sync_reg[0] <= wptr[gi*PW +: PW];
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_reg[k] <= sync_reg[k-1];
                    end
                end
            end

            // Gray to binary: bit j is the XOR of all Gray bits at j and above
            always_comb begin
                bin_next = '0;
                for (int j = 0; j < PW; j++) begin
                    bin_next[j] = ^(sync_reg[SYNC_STAGES-1] >> j);
                end
            end

            // Register the binary pointer and its modular advance and change strobe.
            // After reset the reference value is 0, so the first non-zero pointer
            // reports its whole value as the delta.
            always_ff @(posedge rclk) begin
                if (!rrst_n) begin
                    bin_reg   <= '0;
                    delta_reg <= '0;
                    upd_reg   <= 1'b0;
                end else begin
                    bin_reg   <= bin_next;
                    delta_reg <= bin_next - bin_reg;
                    upd_reg   <= (bin_next != bin_reg);
                end
            end

            assign rq_wptr_gray[gi*PW +: PW]  = sync_reg[SYNC_STAGES-1];
            assign rq_wptr_bin[gi*PW +: PW]   = bin_reg;
            assign rq_wptr_delta[gi*PW +: PW] = delta_reg;
            assign rq_wptr_upd[gi]            = upd_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_ptr_w2r_multi.sv
// Directed bench for sync_ptr_w2r_multi. Instance dut_a uses one channel with a
// 2-deep chain. Instance dut_b uses two channels with a 4-deep chain. Inputs
// change and outputs are sampled 1 time unit after each rising rclk edge.
module tb_sync_ptr_w2r_multi;

    logic       rclk;
    logic       rrst_n;

    logic [4:0] wptr_a;
    logic [4:0] gray_a;
    logic [4:0] bin_a;
    logic [4:0] delta_a;
    logic [0:0] upd_a;

    logic [9:0] wptr_b;
    logic [9:0] gray_b;
    logic [9:0] bin_b;
    logic [9:0] delta_b;
    logic [1:0] upd_b;

    int tests_run;
    int tests_failed;

    sync_ptr_w2r_multi #(.ADDRSIZE(4), .NUM_CH(1), .SYNC_STAGES(2)) dut_a (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .wptr          (wptr_a),
        .rq_wptr_gray  (gray_a),
        .rq_wptr_bin   (bin_a),
        .rq_wptr_delta (delta_a),
        .rq_wptr_upd   (upd_a)
    );

    sync_ptr_w2r_multi #(.ADDRSIZE(4), .NUM_CH(2), .SYNC_STAGES(4)) dut_b (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .wptr          (wptr_b),
        .rq_wptr_gray  (gray_b),
        .rq_wptr_bin   (bin_b),
        .rq_wptr_delta (delta_b),
        .rq_wptr_upd   (upd_b)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    // Move the single-channel pointer from one settled Gray value to another.
    // Then check that the strobe, binary and delta land 3 edges later, for one cycle.
    task automatic run_a(input string tag, input logic [4:0] from_g, input logic [4:0] to_g,
                         input int exp_bin, input int exp_delta);
        wptr_a = from_g;
        step(5);
        check_val({tag, "_settled_upd"}, 32'(upd_a), 0);
        wptr_a = to_g;
        step(1);
        check_val({tag, "_e1_upd"}, 32'(upd_a), 0);
        step(1);
        check_val({tag, "_e2_gray"}, 32'(gray_a), 32'(to_g));
        check_val({tag, "_e2_upd"}, 32'(upd_a), 0);
        step(1);
        check_val({tag, "_bin"}, 32'(bin_a), exp_bin);
        check_val({tag, "_delta"}, 32'(delta_a), exp_delta);
        check_val({tag, "_upd"}, 32'(upd_a), 1);
        step(1);
        check_val({tag, "_upd_drop"}, 32'(upd_a), 0);
        check_val({tag, "_delta_drop"}, 32'(delta_a), 0);
        $display("[TB] %s: gray 0x%02h -> 0x%02h, bin %0d delta %0d", tag, from_g, to_g, exp_bin, exp_delta);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rrst_n       = 1'b0;
        wptr_a       = 5'h1F;
        wptr_b       = 10'h3FF;

        // Reset held for 3 cycles with a non-zero pointer on the input
        for (int c = 0; c < 3; c++) begin
            step(1);
            check_val("rst_gray", 32'(gray_a), 0);
            check_val("rst_bin", 32'(bin_a), 0);
            check_val("rst_delta", 32'(delta_a), 0);
            check_val("rst_upd", 32'(upd_a), 0);
            check_val("rst_b_gray", 32'(gray_b), 0);
            check_val("rst_b_upd", 32'(upd_b), 0);
        end
        $display("[TB] reset: outputs held at zero for 3 cycles");

        // Release: 0x1F (bin 21) is visible as Gray after 2 edges and as binary after 3
        rrst_n = 1'b1;
        step(1);
        check_val("rel_e1_gray", 32'(gray_a), 0);
        step(1);
        check_val("rel_e2_gray", 32'(gray_a), 'h1F);
        check_val("rel_e2_upd", 32'(upd_a), 0);
        step(1);
        check_val("rel_bin", 32'(bin_a), 21);
        check_val("rel_delta", 32'(delta_a), 21);
        check_val("rel_upd", 32'(upd_a), 1);
        step(1);
        check_val("rel_upd_drop", 32'(upd_a), 0);
        check_val("rel_delta_drop", 32'(delta_a), 0);
        check_val("rel_bin_hold", 32'(bin_a), 21);
        $display("[TB] release: gray 0x1F -> bin 21 delta 21");

        run_a("step", 5'h07, 5'h05, 6, 1);
        run_a("wrap", 5'h10, 5'h00, 0, 1);
        run_a("jump", 5'h02, 5'h04, 7, 4);

        // Four-stage, two-channel instance: step ch0 while ch1 holds 0x03
        wptr_b = {5'h03, 5'h00};
        step(8);
        check_val("ch_settled_upd", 32'(upd_b), 0);
        wptr_b = {5'h03, 5'h01};
        for (int e = 1; e <= 4; e++) begin
            step(1);
            check_val("ch_early_upd", 32'(upd_b), 0);
        end
        step(1);
        check_val("ch0_bin", 32'(bin_b[4:0]), 1);
        check_val("ch0_delta", 32'(delta_b[4:0]), 1);
        check_val("ch0_upd", 32'(upd_b[0]), 1);
        check_val("ch1_upd", 32'(upd_b[1]), 0);
        check_val("ch1_delta", 32'(delta_b[9:5]), 0);
        check_val("ch1_bin", 32'(bin_b[9:5]), 2);
        check_val("ch1_gray", 32'(gray_b[9:5]), 'h03);
        step(1);
        check_val("ch0_upd_drop", 32'(upd_b[0]), 0);
        check_val("ch1_upd_hold", 32'(upd_b[1]), 0);
        $display("[TB] channels: ch0 0x00 -> 0x01 delta 1 at edge 5, ch1 held at bin 2");

        // Reset in mid-operation, with the pointer at bin 9
        wptr_a = 5'h0D;
        step(5);
        check_val("mid_pre_bin", 32'(bin_a), 9);
        rrst_n = 1'b0;
        step(1);
        check_val("mid_rst_gray", 32'(gray_a), 0);
        check_val("mid_rst_bin", 32'(bin_a), 0);
        check_val("mid_rst_delta", 32'(delta_a), 0);
        check_val("mid_rst_upd", 32'(upd_a), 0);
        rrst_n = 1'b1;
        step(2);
        check_val("mid_e2_upd", 32'(upd_a), 0);
        step(1);
        check_val("mid_bin", 32'(bin_a), 9);
        check_val("mid_delta", 32'(delta_a), 9);
        check_val("mid_upd", 32'(upd_a), 1);
        $display("[TB] mid reset: cleared, then gray 0x0D -> bin 9 delta 9");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
